// File: rtl/onehot_event_encoder8_if.sv
// Event-encoder bus: request lines in, valid/ready encoded index stream out.
// The encoder side is the master; the consumer side is the slave.
interface onehot_event_encoder8_if;
  logic [7:0] req_in;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;
  logic [7:0] pending;
  logic       overflow;

  modport master (
    input  req_in,
    input  out_ready,
    output out_valid,
    output out_idx,
    output out_onehot,
    output pending,
    output overflow
  );

  modport slave (
    output req_in,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  out_onehot,
    input  pending,
    input  overflow
  );
endinterface

// File: rtl/onehot_event_encoder8.sv
// Sticky 8-line event collector feeding a one-at-a-time 3-bit index encoder
// with a valid/ready output; fixed-priority or round-robin selection.
module onehot_event_encoder8 #(
  parameter bit EDGE_MODE = 1'b0,
  parameter bit RR_MODE   = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  onehot_event_encoder8_if.master        bus
);
  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state_reg;
  logic [7:0] req_d_reg;
  logic [7:0] pending_reg;
  logic [2:0] idx_reg;
  logic [7:0] onehot_reg;
  logic [2:0] last_reg;
  logic       valid_reg;
  logic       overflow_reg;

  logic [7:0] ev;
  logic       acc;
  logic [7:0] idx_dec;
  logic [7:0] clr;
  logic [7:0] cand;
  logic [2:0] base;
  logic [2:0] winner;
  logic [7:0] winner_dec;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign idx_dec[gi]    = (idx_reg == 3'(gi));
      assign winner_dec[gi] = (winner == 3'(gi));
    end
  endgenerate

  assign ev   = EDGE_MODE ? (bus.req_in & ~req_d_reg) : bus.req_in;
  assign acc  = valid_reg & bus.out_ready;
  assign clr  = acc ? idx_dec : 8'h00;
  // Only registered pending bits compete; this cycle's events wait a cycle.
  assign cand = pending_reg & ~clr;
  // The round-robin search restarts just past the index being accepted now.
  assign base = acc ? idx_reg : last_reg;

  always_comb begin
    winner = 3'd0;
    if (RR_MODE) begin
      for (int off = 8; off >= 1; off--) begin
        if (cand[base + 3'(off)]) winner = base + 3'(off);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (cand[i]) winner = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      req_d_reg    <= 8'h00;
      pending_reg  <= 8'h00;
      idx_reg      <= 3'd0;
      onehot_reg   <= 8'h00;
      last_reg     <= 3'd7;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      req_d_reg    <= bus.req_in;
      pending_reg  <= cand | ev;
      overflow_reg <= |(ev & cand);
      if (acc) last_reg <= idx_reg;
      case (state_reg)
        IDLE: begin
          if (|cand) begin
            idx_reg    <= winner;
            onehot_reg <= winner_dec;
            valid_reg  <= 1'b1;
            state_reg  <= OFFER;
          end
        end
        OFFER: begin
          if (bus.out_ready) begin
            if (|cand) begin
              idx_reg    <= winner;
              onehot_reg <= winner_dec;
            end else begin
              onehot_reg <= 8'h00;
              valid_reg  <= 1'b0;
              state_reg  <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.out_valid  = valid_reg;
  assign bus.out_idx    = idx_reg;
  assign bus.out_onehot = onehot_reg;
  assign bus.pending    = pending_reg;
  assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_onehot_event_encoder8.sv
// Bench for onehot_event_encoder8: three instances (level/fixed, edge/fixed,
// level/round-robin) share stimulus; a per-instance reference model tracks them.
module tb_onehot_event_encoder8;
  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       rdy;

  int n_checks = 0;
  int n_fail   = 0;

  onehot_event_encoder8_if bus_l ();
  onehot_event_encoder8_if bus_e ();
  onehot_event_encoder8_if bus_r ();

  assign bus_l.req_in = req;  assign bus_l.out_ready = rdy;
  assign bus_e.req_in = req;  assign bus_e.out_ready = rdy;
  assign bus_r.req_in = req;  assign bus_r.out_ready = rdy;

  onehot_event_encoder8 #(.EDGE_MODE(1'b0), .RR_MODE(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));
  onehot_event_encoder8 #(.EDGE_MODE(1'b1), .RR_MODE(1'b0)) dut_e (.clk(clk), .rst(rst), .bus(bus_e));
  onehot_event_encoder8 #(.EDGE_MODE(1'b0), .RR_MODE(1'b1)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));

  logic       o_valid [3];
  logic [2:0] o_idx   [3];
  logic [7:0] o_oh    [3];
  logic [7:0] o_pend  [3];
  logic       o_ovf   [3];
  assign o_valid[0] = bus_l.out_valid; assign o_idx[0] = bus_l.out_idx; assign o_oh[0] = bus_l.out_onehot;
  assign o_pend[0]  = bus_l.pending;   assign o_ovf[0] = bus_l.overflow;
  assign o_valid[1] = bus_e.out_valid; assign o_idx[1] = bus_e.out_idx; assign o_oh[1] = bus_e.out_onehot;
  assign o_pend[1]  = bus_e.pending;   assign o_ovf[1] = bus_e.overflow;
  assign o_valid[2] = bus_r.out_valid; assign o_idx[2] = bus_r.out_idx; assign o_oh[2] = bus_r.out_onehot;
  assign o_pend[2]  = bus_r.pending;   assign o_ovf[2] = bus_r.overflow;

  // Reference model state, one entry per instance.
  bit       mode_edge [3] = '{1'b0, 1'b1, 1'b0};
  bit       mode_rr   [3] = '{1'b0, 1'b0, 1'b1};
  bit [7:0] m_pend [3];
  bit [7:0] m_reqd [3];
  bit       m_valid[3];
  bit       m_ovf  [3];
  int       m_idx  [3];
  int       m_last [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      int       clr_k;
      int       start;
      int       win;
      int       k;
      bit       ov;
      bit [7:0] ev;
      if (rst) begin
        m_pend[d] = 8'h00; m_reqd[d] = 8'h00; m_valid[d] = 1'b0;
        m_idx[d]  = 0;     m_last[d] = 7;     m_ovf[d]   = 1'b0;
      end else begin
        clr_k = (m_valid[d] && rdy) ? m_idx[d] : -1;
        start = (clr_k >= 0) ? clr_k : m_last[d];
        win   = -1;
        ov    = 1'b0;
        for (int b = 0; b < 8; b++) ev[b] = req[b] && !(mode_edge[d] && m_reqd[d][b]);
        for (int n = 1; n <= 8; n++) begin
          k = mode_rr[d] ? (start + n) % 8 : n - 1;
          if (win < 0 && m_pend[d][k] && k != clr_k) win = k;
        end
        for (int b = 0; b < 8; b++) if (ev[b] && m_pend[d][b] && b != clr_k) ov = 1'b1;
        if (clr_k >= 0) m_last[d] = clr_k;
        if (!m_valid[d] || clr_k >= 0) begin
          if (win >= 0) begin m_valid[d] = 1'b1; m_idx[d] = win; end
          else m_valid[d] = 1'b0;
        end
        if (clr_k >= 0) m_pend[d][clr_k] = 1'b0;
        m_pend[d] = m_pend[d] | ev;
        m_reqd[d] = req;
        m_ovf[d]  = ov;
      end
    end
  endtask

  // Advance one clock; outputs are then inspected half a period later.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00; rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (bus_l.out_idx !== 3'd0)     begin n_fail++; $display("FAIL reset_idx: got %0d want 0", bus_l.out_idx); end
    n_checks++; if (bus_l.out_onehot !== 8'h00) begin n_fail++; $display("FAIL reset_onehot: got %h want 00", bus_l.out_onehot); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (bus_l.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid[%0d]: got %b want 0", i, bus_l.out_valid); end
      n_checks++; if (bus_l.pending !== 8'h00)  begin n_fail++; $display("FAIL idle_pending[%0d]: got %h want 00", i, bus_l.pending); end
      n_checks++; if (bus_l.overflow !== 1'b0)  begin n_fail++; $display("FAIL idle_overflow[%0d]: got %b want 0", i, bus_l.overflow); end
    end
    $display("reset: idle for 10 cycles");
  endtask

  task automatic test_back_to_back();
    int exp_idx[3] = '{2, 5, 7};
    bit [7:0] exp_oh[3] = '{8'h04, 8'h20, 8'h80};
    rdy = 1'b1; req = 8'hA4;
    tick();
    req = 8'h00;
    n_checks++; if (bus_l.pending !== 8'hA4)  begin n_fail++; $display("FAIL b2b_pending: got %h want a4", bus_l.pending); end
    n_checks++; if (bus_l.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_latency: got valid %b want 0", bus_l.out_valid); end
    tick();
    for (int i = 0; i < 3; i++) begin
      $display("grant: idx=%0d onehot=%h", bus_l.out_idx, bus_l.out_onehot);
      n_checks++; if (bus_l.out_valid !== 1'b1)          begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus_l.out_valid); end
      n_checks++; if (bus_l.out_idx !== 3'(exp_idx[i]))  begin n_fail++; $display("FAIL b2b_idx[%0d]: got %0d want %0d", i, bus_l.out_idx, exp_idx[i]); end
      n_checks++; if (bus_l.out_onehot !== exp_oh[i])    begin n_fail++; $display("FAIL b2b_onehot[%0d]: got %h want %h", i, bus_l.out_onehot, exp_oh[i]); end
      tick();
    end
    n_checks++; if (bus_l.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_valid: got %b want 0", bus_l.out_valid); end
    n_checks++; if (bus_l.pending !== 8'h00)  begin n_fail++; $display("FAIL b2b_drain_pending: got %h want 00", bus_l.pending); end
  endtask

  task automatic test_backpressure();
    rdy = 1'b0; req = 8'h40;
    tick();
    req = 8'h00;
    tick();
    for (int i = 0; i < 5; i++) begin
      req = (i == 1) ? 8'h02 : 8'h00;
      tick();
      n_checks++; if (bus_l.out_valid !== 1'b1)  begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus_l.out_valid); end
      n_checks++; if (bus_l.out_idx !== 3'd6)    begin n_fail++; $display("FAIL bp_idx[%0d]: got %0d want 6", i, bus_l.out_idx); end
      n_checks++; if (bus_l.out_onehot !== 8'h40) begin n_fail++; $display("FAIL bp_onehot[%0d]: got %h want 40", i, bus_l.out_onehot); end
    end
    req = 8'h00; rdy = 1'b1;
    tick();
    $display("grant after backpressure: idx=%0d", bus_l.out_idx);
    n_checks++; if (bus_l.out_idx !== 3'd1)     begin n_fail++; $display("FAIL bp_next_idx: got %0d want 1", bus_l.out_idx); end
    n_checks++; if (bus_l.out_onehot !== 8'h02) begin n_fail++; $display("FAIL bp_next_onehot: got %h want 02", bus_l.out_onehot); end
    tick();
    n_checks++; if (bus_l.out_valid !== 1'b0)   begin n_fail++; $display("FAIL bp_drain: got %b want 0", bus_l.out_valid); end
  endtask

  task automatic test_overflow();
    int pulses = 0;
    bit [7:0] seq[5] = '{8'h08, 8'h00, 8'h08, 8'h08, 8'h00};
    bit       exp_ovf[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req = seq[i];
      tick();
      pulses += int'(bus_e.overflow);
      n_checks++; if (bus_e.overflow !== exp_ovf[i]) begin n_fail++; $display("FAIL ovf_pulse[%0d]: got %b want %b", i, bus_e.overflow, exp_ovf[i]); end
      n_checks++; if (bus_e.pending !== 8'h08)       begin n_fail++; $display("FAIL ovf_pending[%0d]: got %h want 08", i, bus_e.pending); end
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL ovf_count: got %0d want 1", pulses); end
    $display("overflow: %0d pulse(s) on bit 3", pulses);
    req = 8'h00; rdy = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (bus_e.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_valid: got %b want 0", bus_e.out_valid); end
    n_checks++; if (bus_e.pending !== 8'h00)  begin n_fail++; $display("FAIL ovf_drain_pending: got %h want 00", bus_e.pending); end
  endtask

  task automatic test_round_robin();
    int rr11[4] = '{0, 4, 0, 4};
    int rr13[6] = '{0, 1, 4, 0, 1, 4};
    int fx13[6] = '{0, 1, 0, 1, 0, 1};
    rst = 1'b1; req = 8'h00; rdy = 1'b1;
    tick();
    rst = 1'b0; req = 8'h11;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      $display("rr grant: idx=%0d", bus_r.out_idx);
      n_checks++; if (bus_r.out_valid !== 1'b1 || bus_r.out_idx !== 3'(rr11[i]))
        begin n_fail++; $display("FAIL rr11[%0d]: got valid %b idx %0d want idx %0d", i, bus_r.out_valid, bus_r.out_idx, rr11[i]); end
      tick();
    end
    rst = 1'b1; req = 8'h00;
    tick();
    rst = 1'b0; req = 8'h13;
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      $display("grant 0x13: rr idx=%0d fixed idx=%0d", bus_r.out_idx, bus_l.out_idx);
      n_checks++; if (bus_r.out_valid !== 1'b1 || bus_r.out_idx !== 3'(rr13[i]))
        begin n_fail++; $display("FAIL rr13[%0d]: got valid %b idx %0d want idx %0d", i, bus_r.out_valid, bus_r.out_idx, rr13[i]); end
      n_checks++; if (bus_l.out_valid !== 1'b1 || bus_l.out_idx !== 3'(fx13[i]))
        begin n_fail++; $display("FAIL fixed13[%0d]: got valid %b idx %0d want idx %0d", i, bus_l.out_valid, bus_l.out_idx, fx13[i]); end
      tick();
    end
    req = 8'h00;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_offer();
    rst = 1'b1; req = 8'h00; rdy = 1'b0;
    tick();
    rst = 1'b0; req = 8'h20;
    tick();
    req = 8'h00;
    tick();
    req = 8'h03;
    tick();
    req = 8'h00;
    n_checks++; if (bus_l.out_valid !== 1'b1 || bus_l.out_idx !== 3'd5)
      begin n_fail++; $display("FAIL mid_offer: got valid %b idx %0d want valid 1 idx 5", bus_l.out_valid, bus_l.out_idx); end
    n_checks++; if (bus_l.pending !== 8'h23) begin n_fail++; $display("FAIL mid_pending: got %h want 23", bus_l.pending); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if ({bus_l.out_valid, bus_l.out_idx, bus_l.out_onehot, bus_l.pending, bus_l.overflow} !== 21'd0)
      begin n_fail++; $display("FAIL mid_reset: got v%b i%0d oh%h p%h o%b want all zero", bus_l.out_valid, bus_l.out_idx, bus_l.out_onehot, bus_l.pending, bus_l.overflow); end
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus_l.out_valid !== 1'b0 || bus_l.pending !== 8'h00)
        begin n_fail++; $display("FAIL post_reset[%0d]: got valid %b pending %h want 0/00", i, bus_l.out_valid, bus_l.pending); end
    end
    $display("reset mid-offer: offer for idx 5 discarded");
  endtask

  task automatic test_random();
    bit [7:0] exp_oh;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      req = 8'($urandom & $urandom & $urandom);
      rdy = ($urandom_range(0, 3) != 0);
      tick();
      for (int d = 0; d < 3; d++) begin
        exp_oh = m_valid[d] ? (8'h01 << m_idx[d]) : 8'h00;
        n_checks++; if (o_valid[d] !== m_valid[d])
          begin n_fail++; $display("FAIL rnd_valid dut%0d cyc%0d: got %b want %b", d, c, o_valid[d], m_valid[d]); end
        n_checks++; if (o_idx[d] !== 3'(m_idx[d]))
          begin n_fail++; $display("FAIL rnd_idx dut%0d cyc%0d: got %0d want %0d", d, c, o_idx[d], m_idx[d]); end
        n_checks++; if (o_oh[d] !== exp_oh)
          begin n_fail++; $display("FAIL rnd_onehot dut%0d cyc%0d: got %h want %h", d, c, o_oh[d], exp_oh); end
        n_checks++; if (o_pend[d] !== m_pend[d])
          begin n_fail++; $display("FAIL rnd_pending dut%0d cyc%0d: got %h want %h", d, c, o_pend[d], m_pend[d]); end
        n_checks++; if (o_ovf[d] !== m_ovf[d])
          begin n_fail++; $display("FAIL rnd_overflow dut%0d cyc%0d: got %b want %b", d, c, o_ovf[d], m_ovf[d]); end
      end
    end
    $display("random: 600 cycles compared on 3 instances");
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; rdy = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_round_robin();
    test_reset_mid_offer();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
